instruction_decoder_pipe: RTL and testbench
===========================================

// Module: instruction_decoder_pipe
// PURPOSE
// - Parametrised successor of the enable-gated instruction decoder.
// - Splits a fetched instruction word into opcode, rD/rA/rB, flag and imm fields; flags illegal opcodes.
// - Adds extended immediate and a valid/ready 2-entry skid buffer, so fetch and execute run at full rate with backpressure.
// - Sits between fetch and register-file/ALU issue.
// PARAMETERS
// INSTR_W       16        instruction width; must equal OPC_W+REG_AW+1+IMM_W (elaboration error otherwise)
// OPC_W         4         opcode field width
// REG_AW        3         register address width (rD, rA, rB)
// IMM_W         8         immediate field width; must be >= 2*REG_AW
// DATA_W        16        extended immediate width; must be >= IMM_W
// IMM_MODE      0         0 = zero-extend; 1 = sign-extend; 2 = sign-extend iff flag=1, else zero-extend
// ILLEGAL_MASK  '0        2**OPC_W bits; bit k=1 marks opcode k illegal
// PORTS
// clock      in   1        rising-edge clock
// reset_n    in   1        asynchronous active-low reset
// in_valid   in   1        instruct valid
// in_ready   out  1        buffer can accept
// instruct   in   INSTR_W  instruction word
// flush      in   1        synchronous discard of all buffered entries
// out_valid  out  1        decoded head entry valid
// out_ready  in   1        consumer accepts head entry
// opcode     out  OPC_W    instruct[INSTR_W-1 -: OPC_W]
// rDadrs     out  REG_AW   next REG_AW bits below opcode
// flag       out  1        bit IMM_W
// rAadrs     out  REG_AW   instruct[IMM_W-1 -: REG_AW]
// rBadrs     out  REG_AW   instruct[IMM_W-1-REG_AW -: REG_AW]
// imm        out  IMM_W    instruct[IMM_W-1:0]
// imm_ext    out  DATA_W   imm extended per IMM_MODE
// illegal    out  1        head opcode has ILLEGAL_MASK bit set
// ill_count  out  8        saturating count of accepted illegal instructions
// BEHAVIOUR
// - Default field split: opcode[15:12] rD[11:9] flag[8] rA[7:5] rB[4:2] imm[7:0].
// - Reset (async assert, sync release): count=0, out_valid=0, in_ready=1, ill_count=0, all field outputs 0.
// - push = in_valid & in_ready; pop = out_valid & out_ready.
// - Decode, extension and illegal check happen at push; entries store decoded fields.
// - Outputs are driven from registers only.
// - Latency: word pushed at edge N appears on outputs after edge N with out_valid=1. Throughput is 1/cycle.
// - Storage is head/tail slots with count in {0,1,2}:
// - count 0: push -> head, count=1.
// - count 1: push only -> tail, count=2. Pop only -> count=0. Push+pop -> new word to head, count=1.
// - count 2: push impossible. Pop -> tail moves to head, count=1.
// - in_ready = (count!=2), registered.
// - Head outputs hold stable while out_valid & !out_ready. Field values when out_valid=0 are don't-care (verify only under valid).
// - Flush: count=0 and out_valid=0 next cycle; it wins over a simultaneous push (word dropped) and pop.
// - Flush does not clear ill_count.
// - ill_count: +1 per pushed illegal word, not on flushed-away pushes; holds at 255.
// - Reset mid-transfer discards all entries immediately.
// STRUCTURE
// - Package instruction_decoder_pkg:
//   - decoded_t struct {opcode, rD, rA, rB, flag, imm, imm_ext, illegal};
//   - IMM_ZERO/IMM_SIGN/IMM_FLAG localparams;
//   - field-offset functions.
// - One sub-module, instr_field_decode: combinational word -> decoded_t, parametrised identically.
// - Skid buffer and counter live in the top.
// TESTING
// - Reset then push 16'hA5F3 (defaults, IMM_MODE=0): next cycle opcode=A, rD=2, flag=1, rA=7, rB=4, imm=F3, imm_ext=00F3.
// - IMM_MODE=2: push 16'h11F0 (flag=1) -> imm_ext=FFF0. Push 16'h10F0 (flag=0) -> imm_ext=00F0.
// - out_ready=0, push 3 words back-to-back: 2 accepted, in_ready=0 on 3rd. Release -> words drain in order, no loss or duplicate.
// - Continuous in_valid and out_ready=1: 100 words in 101 cycles, in_ready never drops.
// - ILLEGAL_MASK bit F set: push 300 words with opcode F -> illegal=1 on each, ill_count=255.
// - count=2, then flush with in_valid=1 -> out_valid=0 next cycle, pushed word dropped, ill_count unchanged.

Source files
------------

// File: rtl/instruction_decoder_pkg.sv
// instruction_decoder_pkg: shared types, extension modes and field offsets for the pipelined instruction decoder.
// Decoded entries use fixed maximum widths so one struct serves every parameterisation.
package instruction_decoder_pkg;

    localparam int OPC_MAX  = 8;
    localparam int REG_MAX  = 8;
    localparam int IMM_MAX  = 32;
    localparam int DATA_MAX = 64;

    localparam int IMM_ZERO = 0;
    localparam int IMM_SIGN = 1;
    localparam int IMM_FLAG = 2;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} fill_t;

    typedef struct packed {
        logic [OPC_MAX-1:0]  opcode;
        logic [REG_MAX-1:0]  rd;
        logic [REG_MAX-1:0]  ra;
        logic [REG_MAX-1:0]  rb;
        logic                flag;
        logic [IMM_MAX-1:0]  imm;
        logic [DATA_MAX-1:0] imm_ext;
        logic                illegal;
    } decoded_t;

    function automatic int rd_lsb(input int instr_w, input int opc_w, input int reg_aw);
        return instr_w - opc_w - reg_aw;
    endfunction

    function automatic int ra_lsb(input int imm_w, input int reg_aw);
        return imm_w - reg_aw;
    endfunction

    function automatic int rb_lsb(input int imm_w, input int reg_aw);
        return imm_w - 2 * reg_aw;
    endfunction

endpackage

// File: rtl/instruction_decoder_pipe_if.sv
// instruction_decoder_pipe_if: fetch-side push, execute-side pop and decoded field bundle.
interface instruction_decoder_pipe_if #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int REG_AW  = 3,
    parameter int IMM_W   = 8,
    parameter int DATA_W  = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instruct;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [OPC_W-1:0]   opcode;
    logic [REG_AW-1:0]  rDadrs;
    logic               flag;
    logic [REG_AW-1:0]  rAadrs;
    logic [REG_AW-1:0]  rBadrs;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W-1:0]  imm_ext;
    logic               illegal;
    logic [7:0]         ill_count;

    modport master (
        output in_valid, instruct, flush, out_ready,
        input  in_ready, out_valid, opcode, rDadrs, flag, rAadrs, rBadrs, imm, imm_ext, illegal, ill_count
    );

    modport slave (
        input  in_valid, instruct, flush, out_ready,
        output in_ready, out_valid, opcode, rDadrs, flag, rAadrs, rBadrs, imm, imm_ext, illegal, ill_count
    );

endinterface

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational split of an instruction word into decoded fields with immediate extension.
module instr_field_decode
    import instruction_decoder_pkg::*;
#(
    parameter int                     INSTR_W      = 16,
    parameter int                     OPC_W        = 4,
    parameter int                     REG_AW       = 3,
    parameter int                     IMM_W        = 8,
    parameter int                     DATA_W       = 16,
    parameter int                     IMM_MODE     = IMM_ZERO,
    parameter logic [2**OPC_W-1:0]    ILLEGAL_MASK = '0
) (
    input  logic [INSTR_W-1:0] word,
    output decoded_t           dec
);

    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] ext;
    logic              sx;

    always_comb begin
        imm = word[IMM_W-1:0];
        sx = (IMM_MODE == IMM_SIGN) || (IMM_MODE == IMM_FLAG && word[IMM_W]);
        ext = sx ? DATA_W'($signed(imm)) : DATA_W'(imm);
        dec = '0;
        dec.opcode = OPC_MAX'(word[INSTR_W-1 -: OPC_W]);
        dec.rd = REG_MAX'(word[rd_lsb(INSTR_W, OPC_W, REG_AW) +: REG_AW]);
        dec.flag = word[IMM_W];
        dec.ra = REG_MAX'(word[ra_lsb(IMM_W, REG_AW) +: REG_AW]);
        dec.rb = REG_MAX'(word[rb_lsb(IMM_W, REG_AW) +: REG_AW]);
        dec.imm = IMM_MAX'(imm);
        dec.imm_ext = DATA_MAX'(ext);
        dec.illegal = ILLEGAL_MASK[word[INSTR_W-1 -: OPC_W]];
    end

endmodule

// File: rtl/instruction_decoder_pipe.sv
// instruction_decoder_pipe: decodes at push into a 2-entry head/tail skid buffer with registered handshakes.
// Keeps a saturating count of accepted illegal opcodes that survives flush.
module instruction_decoder_pipe
    import instruction_decoder_pkg::*;
#(
    parameter int                     INSTR_W      = 16,
    parameter int                     OPC_W        = 4,
    parameter int                     REG_AW       = 3,
    parameter int                     IMM_W        = 8,
    parameter int                     DATA_W       = 16,
    parameter int                     IMM_MODE     = IMM_ZERO,
    parameter logic [2**OPC_W-1:0]    ILLEGAL_MASK = '0
) (
    input logic                 clock,
    input logic                 reset_n,
    instruction_decoder_pipe_if.slave bus
);

    if (INSTR_W != OPC_W + REG_AW + 1 + IMM_W) begin : g_bad_instr_w
        $error("INSTR_W must equal OPC_W+REG_AW+1+IMM_W");
    end
    if (IMM_W < 2 * REG_AW) begin : g_bad_imm_w
        $error("IMM_W must be >= 2*REG_AW");
    end
    if (DATA_W < IMM_W) begin : g_bad_data_w
        $error("DATA_W must be >= IMM_W");
    end
    if (OPC_W > OPC_MAX || REG_AW > REG_MAX || IMM_W > IMM_MAX || DATA_W > DATA_MAX) begin : g_too_wide
        $error("field width exceeds decoded_t capacity");
    end

    decoded_t   dec, head, tail, head_n, tail_n;
    fill_t      state, state_n;
    logic [7:0] ill_count, ill_n;
    logic       out_valid, in_ready, push, pop;
    logic       unused_head;

    instr_field_decode #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_AW(REG_AW), .IMM_W(IMM_W),
        .DATA_W(DATA_W), .IMM_MODE(IMM_MODE), .ILLEGAL_MASK(ILLEGAL_MASK)
    ) u_decode (
        .word (bus.instruct),
        .dec  (dec)
    );

    assign push = bus.in_valid & in_ready;
    assign pop  = out_valid & bus.out_ready;

    always_comb begin
        state_n = state;
        head_n = head;
        tail_n = tail;
        if (bus.flush) begin
            state_n = EMPTY;
        end else if (state == EMPTY) begin
            if (push) begin
                head_n = dec;
                state_n = ONE;
            end
        end else if (state == ONE) begin
            if (push && pop) begin
                head_n = dec;
            end else if (push) begin
                tail_n = dec;
                state_n = FULL;
            end else if (pop) begin
                state_n = EMPTY;
            end
        end else if (pop) begin
            head_n = tail;
            state_n = ONE;
        end
        // a flushed push never reached the buffer, so it is not counted
        ill_n = (push && !bus.flush && dec.illegal && ill_count != 8'hFF) ? ill_count + 8'd1 : ill_count;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            head <= '0;
            tail <= '0;
            ill_count <= '0;
            out_valid <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            state <= state_n;
            head <= head_n;
            tail <= tail_n;
            ill_count <= ill_n;
            out_valid <= state_n != EMPTY;
            in_ready <= state_n != FULL;
        end
    end

    assign unused_head   = ^head;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.opcode    = head.opcode[OPC_W-1:0];
    assign bus.rDadrs    = head.rd[REG_AW-1:0];
    assign bus.flag      = head.flag;
    assign bus.rAadrs    = head.ra[REG_AW-1:0];
    assign bus.rBadrs    = head.rb[REG_AW-1:0];
    assign bus.imm       = head.imm[IMM_W-1:0];
    assign bus.imm_ext   = head.imm_ext[DATA_W-1:0];
    assign bus.illegal   = head.illegal;
    assign bus.ill_count = ill_count;

endmodule

// File: tb/tb_instruction_decoder_pipe.sv
// tb_instruction_decoder_pipe: randomized checks of two decoder instances against a queue-based reference model.
module tb_instruction_decoder_pipe;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instruction_decoder_pipe_if b0 ();
    instruction_decoder_pipe_if b2 ();

    instruction_decoder_pipe #(.IMM_MODE(0), .ILLEGAL_MASK(16'h8000)) u0 (.clock(clk), .reset_n(reset_n), .bus(b0));
    instruction_decoder_pipe #(.IMM_MODE(2), .ILLEGAL_MASK(16'h0000)) u2 (.clock(clk), .reset_n(reset_n), .bus(b2));

    int          checks = 0;
    int          errors = 0;
    int          ill_m = 0;
    logic [15:0] q[$];
    logic [15:0] mask0 = 16'h8000;
    logic [15:0] mask2 = 16'h0000;

    wire [38:0] obs0 = {b0.opcode, b0.rDadrs, b0.flag, b0.rAadrs, b0.rBadrs, b0.imm, b0.imm_ext, b0.illegal};
    wire [38:0] obs2 = {b2.opcode, b2.rDadrs, b2.flag, b2.rAadrs, b2.rBadrs, b2.imm, b2.imm_ext, b2.illegal};

    // expected fields from plain arithmetic on the word
    function automatic logic [38:0] exp_fields(input logic [15:0] w, input int mode, input logic [15:0] mask);
        int op, rd, fl, imm, ext;
        op = int'(w) / 4096;
        rd = (int'(w) / 512) % 8;
        fl = (int'(w) / 256) % 2;
        imm = int'(w) % 256;
        ext = ((mode == 1 || (mode == 2 && fl == 1)) && imm >= 128) ? imm + 65280 : imm;
        return {4'(op), 3'(rd), 1'(fl), 3'(imm / 32), 3'((imm / 4) % 8), 8'(imm), 16'(ext), mask[op]};
    endfunction

    task automatic drive(input logic v, input logic [15:0] w, input logic r, input logic f);
        logic push, pop;
        b0.in_valid = v;
        b0.instruct = w;
        b0.out_ready = r;
        b0.flush = f;
        push = v && q.size() < 2;
        pop = r && q.size() > 0;
        @(posedge clk);
        #1;
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(w);
        end
        if (push && !f && mask0[w[15:12]] && ill_m < 255) ill_m++;
    endtask

    task automatic test_reset;
        b0.in_valid = 0; b0.instruct = 0; b0.out_ready = 0; b0.flush = 0;
        b2.in_valid = 0; b2.instruct = 0; b2.out_ready = 0; b2.flush = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks += 4;
        if (b0.out_valid !== 1'b0 || b2.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: %b %b want 0 0", b0.out_valid, b2.out_valid); end
        if (b0.in_ready !== 1'b1 || b2.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: %b %b want 1 1", b0.in_ready, b2.in_ready); end
        if (b0.ill_count !== 8'd0) begin errors++; $display("FAIL reset ill_count: %0d want 0", b0.ill_count); end
        if (obs0 !== 39'd0 || obs2 !== 39'd0) begin errors++; $display("FAIL reset fields: %h %h want 0", obs0, obs2); end
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        ill_m = 0;
    endtask

    task automatic test_basic;
        drive(1, 16'hA5F3, 0, 0);
        checks += 8;
        if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL basic out_valid: %b want 1", b0.out_valid); end
        if (b0.opcode !== 4'hA) begin errors++; $display("FAIL basic opcode: %h want a", b0.opcode); end
        if (b0.rDadrs !== 3'd2) begin errors++; $display("FAIL basic rD: %0d want 2", b0.rDadrs); end
        if (b0.flag !== 1'b1) begin errors++; $display("FAIL basic flag: %b want 1", b0.flag); end
        if (b0.rAadrs !== 3'd7) begin errors++; $display("FAIL basic rA: %0d want 7", b0.rAadrs); end
        if (b0.rBadrs !== 3'd4) begin errors++; $display("FAIL basic rB: %0d want 4", b0.rBadrs); end
        if (b0.imm !== 8'hF3) begin errors++; $display("FAIL basic imm: %h want f3", b0.imm); end
        if (b0.imm_ext !== 16'h00F3) begin errors++; $display("FAIL basic imm_ext: %h want 00f3", b0.imm_ext); end
        drive(0, 16'h0000, 1, 0);
        checks++;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL basic drain: out_valid=%b want 0", b0.out_valid); end
    endtask

    task automatic test_imm_mode;
        logic [15:0] prev, w;
        b2.out_ready = 1; b2.flush = 0; b2.in_valid = 1; b2.instruct = 16'h11F0;
        @(posedge clk); #1;
        b2.instruct = 16'h10F0;
        checks++;
        if (b2.out_valid !== 1'b1 || b2.imm_ext !== 16'hFFF0) begin errors++; $display("FAIL imm_flag1: valid=%b ext=%h want 1 fff0", b2.out_valid, b2.imm_ext); end
        @(posedge clk); #1;
        checks++;
        if (b2.out_valid !== 1'b1 || b2.imm_ext !== 16'h00F0) begin errors++; $display("FAIL imm_flag0: valid=%b ext=%h want 1 00f0", b2.out_valid, b2.imm_ext); end
        prev = 16'h10F0;
        for (int i = 0; i < 30; i++) begin
            w = 16'($urandom);
            b2.instruct = w;
            @(posedge clk); #1;
            checks++;
            if (b2.out_valid !== 1'b1 || obs2 !== exp_fields(w, 2, mask2)) begin errors++; $display("FAIL imm_rand: got %h want %h", obs2, exp_fields(w, 2, mask2)); end
            prev = w;
        end
        b2.in_valid = 0;
        @(posedge clk); #1;
        checks++;
        if (b2.out_valid !== 1'b0) begin errors++; $display("FAIL imm_drain: out_valid=%b want 0 after %h", b2.out_valid, prev); end
    endtask

    task automatic test_backpressure;
        logic [15:0] w[3];
        for (int i = 0; i < 3; i++) w[i] = 16'($urandom);
        for (int i = 0; i < 3; i++) drive(1, w[i], 0, 0);
        checks += 2;
        if (b0.in_ready !== 1'b0 || q.size() != 2) begin errors++; $display("FAIL bp full: in_ready=%b depth=%0d want 0 2", b0.in_ready, q.size()); end
        if (obs0 !== exp_fields(w[0], 0, mask0)) begin errors++; $display("FAIL bp hold: got %h want %h", obs0, exp_fields(w[0], 0, mask0)); end
        drive(0, 16'h0000, 1, 0);
        checks++;
        if (b0.out_valid !== 1'b1 || obs0 !== exp_fields(w[1], 0, mask0)) begin errors++; $display("FAIL bp order: got %h want %h", obs0, exp_fields(w[1], 0, mask0)); end
        drive(0, 16'h0000, 1, 0);
        checks++;
        if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin errors++; $display("FAIL bp empty: valid=%b ready=%b want 0 1", b0.out_valid, b0.in_ready); end
    endtask

    task automatic test_flush;
        int ill_before;
        drive(1, 16'h1234, 0, 0);
        drive(1, 16'h2345, 0, 0);
        ill_before = ill_m;
        drive(1, 16'hF123, 0, 1);
        checks += 2;
        if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin errors++; $display("FAIL flush full: valid=%b ready=%b want 0 1", b0.out_valid, b0.in_ready); end
        if (b0.ill_count !== 8'(ill_before)) begin errors++; $display("FAIL flush full ill: %0d want %0d", b0.ill_count, ill_before); end
        drive(1, 16'hF000, 0, 0);
        ill_before = ill_m;
        drive(1, 16'hF111, 0, 1);
        checks += 2;
        if (b0.out_valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL flush push: valid=%b want 0", b0.out_valid); end
        if (b0.ill_count !== 8'(ill_before)) begin errors++; $display("FAIL flush push ill: %0d want %0d", b0.ill_count, ill_before); end
        drive(0, 16'h0000, 0, 0);
        checks++;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL flush dropped: out_valid=%b want 0", b0.out_valid); end
    endtask

    task automatic test_full_rate;
        int seen = 0;
        for (int i = 0; i < 101; i++) begin
            checks++;
            if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL rate in_ready: dropped at cycle %0d", i); end
            drive(i < 100, 16'($urandom), 1, 0);
            if (b0.out_valid === 1'b1) seen++;
            checks++;
            if (q.size() != 0 && obs0 !== exp_fields(q[0], 0, mask0)) begin errors++; $display("FAIL rate fields: got %h want %h", obs0, exp_fields(q[0], 0, mask0)); end
        end
        checks += 2;
        if (seen != 100) begin errors++; $display("FAIL rate count: %0d words want 100", seen); end
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rate drain: out_valid=%b want 0", b0.out_valid); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 500; i++) begin
            drive($urandom % 4 != 0, 16'($urandom), $urandom % 3 != 0, $urandom % 20 == 0);
            checks += 3;
            if (b0.out_valid !== (q.size() != 0) || b0.in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand hs: valid=%b ready=%b want %b %b", b0.out_valid, b0.in_ready, q.size() != 0, q.size() < 2); end
            if (q.size() != 0 && obs0 !== exp_fields(q[0], 0, mask0)) begin errors++; $display("FAIL rand fields: got %h want %h", obs0, exp_fields(q[0], 0, mask0)); end
            if (b0.ill_count !== 8'(ill_m)) begin errors++; $display("FAIL rand ill: %0d want %0d", b0.ill_count, ill_m); end
        end
    endtask

    task automatic test_illegal;
        for (int i = 0; i < 301; i++) begin
            drive(i < 300, {4'hF, 12'($urandom)}, 1, 0);
            checks += 2;
            if (q.size() != 0 && (b0.illegal !== 1'b1 || obs0 !== exp_fields(q[0], 0, mask0))) begin errors++; $display("FAIL illegal head: got %h want %h", obs0, exp_fields(q[0], 0, mask0)); end
            if (b0.ill_count !== 8'(ill_m)) begin errors++; $display("FAIL illegal count: %0d want %0d", b0.ill_count, ill_m); end
        end
        checks++;
        if (b0.ill_count !== 8'd255) begin errors++; $display("FAIL illegal saturate: %0d want 255", b0.ill_count); end
    endtask

    task automatic test_reset_mid;
        drive(1, 16'h3333, 0, 0);
        drive(1, 16'h4444, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checks += 2;
        if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin errors++; $display("FAIL mid reset hs: valid=%b ready=%b want 0 1", b0.out_valid, b0.in_ready); end
        if (b0.ill_count !== 8'd0) begin errors++; $display("FAIL mid reset ill: %0d want 0", b0.ill_count); end
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        ill_m = 0;
        @(posedge clk); #1;
        drive(1, 16'hA5F3, 1, 0);
        checks++;
        if (b0.out_valid !== 1'b1 || obs0 !== exp_fields(16'hA5F3, 0, mask0)) begin errors++; $display("FAIL mid reset resume: got %h want %h", obs0, exp_fields(16'hA5F3, 0, mask0)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm_mode();
        test_backpressure();
        test_flush();
        test_full_rate();
        test_random();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
